io_port_arbiter: RTL and testbench
==================================

Name: io_port_arbiter

Overview:
- Shares the single memory-mapped simple I/O port (4-bit addr, 32-bit write data, write enable, 32-bit registered read data) between two masters.
- M0 is the CPU load/store path. M1 is an auxiliary master (display refresh / debug injector).
- Sequences each access as issue then response, and accounts for the port's one-cycle registered read latency.
- Arbitration is fixed priority M0 > M1 with a starvation guard for M1.

Parameters:
- ADDR_W, 4: I/O address width.
- DATA_W, 32: data width.
- MAX_WAIT, 8: cycles M1 may wait while requesting before it is forced to win; legal range 1..255.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- m0_req  in  1  M0 access request; held with m0_addr/m0_we/m0_wdata stable until m0_gnt.
- m0_we  in  1  1 = write, 0 = read.
- m0_addr  in  ADDR_W  M0 target address.
- m0_wdata  in  DATA_W  M0 write data.
- m0_gnt  out  1  one-cycle pulse; M0 access is on the port this cycle.
- m0_rvalid  out  1  one-cycle pulse; M0 access complete (read data valid, or write acknowledged).
- m0_rdata  out  DATA_W  M0 read data, valid with m0_rvalid.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata  same as the M0 set, for M1.
- io_addr  out  ADDR_W  to the port address input.
- io_wdata  out  DATA_W  to the port write-data input.
- io_we  out  1  to the port write enable.
- io_rdata  in  DATA_W  from the port read data (registered in the port; valid the cycle after the address is presented).
- busy  out  1  high in ISSUE or RESP.

Behaviour:
- Reset (async, resetn=0): state=IDLE; io_addr=0, io_wdata=0, io_we=0; all gnt/rvalid=0; rdata=0; owner=M0; wait_cnt=0; busy=0. Reset mid-transaction abandons it with no rvalid. A write already sampled by the port is not undone.
- States:
  - IDLE: if any req is high, arbitrate, latch the winner's addr/we/wdata into io_* registers and its id into owner, then go to ISSUE. Otherwise stay in IDLE.
  - ISSUE (1 cycle): io_* driven from the latches; io_we = latched we; gnt of owner = 1. Next state is RESP.
  - RESP (1 cycle): io_we=0; rvalid of owner = 1; rdata of owner = io_rdata (for writes rdata is don't-care and keeps its previous value). In the same edge, arbitrate any pending req: go to ISSUE if a req is pending, else IDLE.
- Latency:
  - Request seen in IDLE at cycle N: gnt in N+1, rvalid in N+2.
  - Back-to-back throughput: one access per 2 cycles.
- Outside ISSUE, io_we=0. io_addr/io_wdata hold their last values (no glitching the read mux).
- Arbitration: M0 wins unless m1_req && wait_cnt >= MAX_WAIT, in which case M1 wins.
- wait_cnt:
  - Increments (saturating at MAX_WAIT) each cycle m1_req=1 and M1 is not being latched.
  - Clears when M1 wins or when m1_req=0.
- Masters may drop req the cycle after their gnt. A req still high after gnt is treated as a new request.
- Simultaneous m0_req and m1_req with wait_cnt < MAX_WAIT: M0 wins and M1 keeps counting.
- rdata outputs are registered and hold until the next rvalid for that master.

Optional Feature:
- IO_ARB_RR_EN defined: fixed priority and wait_cnt are removed; MAX_WAIT is ignored. Arbitration is round-robin: on a tie the master not equal to last owner wins. last owner resets to M1, so M0 wins the first tie.
- Undefined: fixed priority with the starvation guard, as described in Behaviour.

Decomposition:
- Package io_arb_pkg holds:
  - state enum {IDLE, ISSUE, RESP};
  - owner id constants M0=0, M1=1;
  - I/O address constants: HEX01=0, HEX23=1, HEX45=2, SW_LO=3, SW_HI=4, OPERATOR=5.
- Sub-module io_arb_pick: combinational winner select. Inputs: reqs, wait_cnt_hit, last_owner. Outputs: winner, any. Both policies live inside it under the macro.

Test Plan:
- Single read: m0_req, addr=3, io_rdata model returns 32'h0000_0015 one cycle after address → m0_gnt at N+1, m0_rvalid with m0_rdata=32'h15 at N+2, io_we never high.
- Single write: m1_req, we=1, addr=1, wdata=32'h0000_00A5 → io_we=1 only in the ISSUE cycle with io_addr=1, io_wdata=32'hA5; m1_rvalid at N+2.
- Contention: m0_req and m1_req held high continuously, MAX_WAIT=8 → M0 is granted until wait_cnt reaches 8, then one M1 grant, then wait_cnt=0; grants are spaced 2 cycles apart.
- Back-to-back: M0 issues 4 reads with req held high → gnt pulses at cycles 1, 3, 5, 7 and rvalid pulses at 2, 4, 6, 8; busy stays high throughout.
- Reset mid-operation: resetn low during RESP → all outputs go to reset values immediately, no rvalid is produced, and a fresh request after release completes normally.
- With IO_ARB_RR_EN: both masters request continuously → grants alternate M0, M1, M0, M1.

Source files
------------

// File: rtl/io_arb_pkg.sv
// io_arb_pkg: shared types and constants for the I/O port arbiter.
//   state_t    - sequencer states (IDLE, ISSUE, RESP)
//   M0 / M1    - owner ids (CPU load/store path, auxiliary master)
//   HEX01..    - I/O address map of the simple port
// Build option: IO_ARB_RR_EN selects round-robin arbitration (see io_arb_pick).
package io_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam logic [3:0] HEX01    = 4'd0;
    localparam logic [3:0] HEX23    = 4'd1;
    localparam logic [3:0] HEX45    = 4'd2;
    localparam logic [3:0] SW_LO    = 4'd3;
    localparam logic [3:0] SW_HI    = 4'd4;
    localparam logic [3:0] OPERATOR = 4'd5;

endpackage

// File: rtl/io_arb_pick.sv
// io_arb_pick: combinational winner select between M0 and M1.
// Ports:
//   reqs[1:0]     in  {m1_req, m0_req}
//   wait_cnt_hit  in  M1 has waited MAX_WAIT cycles (fixed-priority build only)
//   last_owner    in  owner of the previous access (round-robin build only)
//   winner        out id of the winning master (M0/M1), valid when any=1
//   any           out at least one request pending
// Build option: IO_ARB_RR_EN defined -> round-robin on ties;
//               undefined -> fixed priority M0 > M1 with starvation guard.
module io_arb_pick
    import io_arb_pkg::*;
(
    input  logic [1:0] reqs,
    input  logic       wait_cnt_hit,
    input  logic       last_owner,
    output logic       winner,
    output logic       any
);

    assign any = |reqs;

`ifdef IO_ARB_RR_EN
    logic unused_wait_cnt_hit;
    assign unused_wait_cnt_hit = wait_cnt_hit;

    always_comb begin
        winner = M0;
        if (reqs[0] && reqs[1]) begin
            winner = ~last_owner;
        end else if (reqs[1]) begin
            winner = M1;
        end
    end
`else
    logic unused_last_owner;
    assign unused_last_owner = last_owner;

    // M1 wins only when it is alone or when it has been starved long enough.
    always_comb begin
        winner = M0;
        if (reqs[1] && (!reqs[0] || wait_cnt_hit)) begin
            winner = M1;
        end
    end
`endif

endmodule

// File: rtl/io_port_arbiter.sv
// io_port_arbiter: shares one registered-read simple I/O port between two
// masters. Each access is sequenced ISSUE (address/write on the port) then
// RESP (port read data is valid, response returned to the owner).
// Ports:
//   clock, resetn                 clock / async active-low reset
//   mN_req, mN_we, mN_addr,       master N request, held until mN_gnt
//   mN_wdata
//   mN_gnt                        pulse: master N access on the port
//   mN_rvalid, mN_rdata           pulse: master N access complete, read data
//   io_addr, io_wdata, io_we      to the port
//   io_rdata                      from the port, valid one cycle after address
//   busy                          high in ISSUE or RESP
// Build option: IO_ARB_RR_EN selects round-robin arbitration (MAX_WAIT unused).
//
// state | meaning
// IDLE  | no access in flight; arbitrate and latch winner on any request
// ISSUE | latched access driven on the port; owner's gnt pulses
// RESP  | port read data valid; owner's rvalid pulses; re-arbitrate
module io_port_arbiter
    import io_arb_pkg::*;
#(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] io_addr,
    output logic [DATA_W-1:0] io_wdata,
    output logic              io_we,
    input  logic [DATA_W-1:0] io_rdata,
    output logic              busy
);

    state_t            state, state_nxt;
    logic              owner;
    logic              we_lat;
    logic              winner, any, latch_en;
    logic              wait_cnt_hit, last_owner;
    logic              rd_resp;
    logic [DATA_W-1:0] m0_rdata_q, m1_rdata_q;

    assign latch_en = any && ((state == IDLE) || (state == RESP));

    io_arb_pick u_pick (
        .reqs         ({m1_req, m0_req}),
        .wait_cnt_hit (wait_cnt_hit),
        .last_owner   (last_owner),
        .winner       (winner),
        .any          (any)
    );

`ifdef IO_ARB_RR_EN
    logic [7:0] unused_max_wait;
    assign unused_max_wait = 8'(MAX_WAIT);
    assign wait_cnt_hit    = 1'b0;

    // Starts at M1 so the first tie goes to M0.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            last_owner <= M1;
        end else if (latch_en) begin
            last_owner <= winner;
        end
    end
`else
    logic [7:0] wait_cnt;
    assign wait_cnt_hit = (wait_cnt >= 8'(MAX_WAIT));
    assign last_owner   = M0;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wait_cnt <= 8'd0;
        end else if (!m1_req || (latch_en && (winner == M1))) begin
            wait_cnt <= 8'd0;
        end else if (!wait_cnt_hit) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            owner      <= M0;
            we_lat     <= 1'b0;
            io_addr    <= '0;
            io_wdata   <= '0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (latch_en) begin
                owner    <= winner;
                we_lat   <= (winner == M1) ? m1_we    : m0_we;
                io_addr  <= (winner == M1) ? m1_addr  : m0_addr;
                io_wdata <= (winner == M1) ? m1_wdata : m0_wdata;
            end
            if (rd_resp && (owner == M0)) begin
                m0_rdata_q <= io_rdata;
            end
            if (rd_resp && (owner == M1)) begin
                m1_rdata_q <= io_rdata;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        io_we     = 1'b0;
        m0_gnt    = 1'b0;
        m1_gnt    = 1'b0;
        m0_rvalid = 1'b0;
        m1_rvalid = 1'b0;
        busy      = 1'b0;
        rd_resp   = 1'b0;
        case (state)
            IDLE: begin
                if (any) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                busy      = 1'b1;
                io_we     = we_lat;
                m0_gnt    = (owner == M0);
                m1_gnt    = (owner == M1);
                state_nxt = RESP;
            end
            RESP: begin
                busy      = 1'b1;
                rd_resp   = !we_lat;
                m0_rvalid = (owner == M0);
                m1_rvalid = (owner == M1);
                state_nxt = any ? ISSUE : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // The port already registers its read data, so during RESP the data is
    // passed straight through to keep rdata aligned with rvalid; the holding
    // register keeps it until that master's next read completes.
    assign m0_rdata = (rd_resp && (owner == M0)) ? io_rdata : m0_rdata_q;
    assign m1_rdata = (rd_resp && (owner == M1)) ? io_rdata : m1_rdata_q;

endmodule

// File: tb/tb_io_port_arbiter.sv
module tb_io_port_arbiter;
    import io_arb_pkg::*;

    logic        clock, resetn;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [3:0]  m0_addr, m1_addr, io_addr;
    logic [31:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, io_wdata, io_rdata;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, io_we, busy;

    int errors = 0;
    int checks = 0;

    io_port_arbiter #(.ADDR_W(4), .DATA_W(32), .MAX_WAIT(8)) dut (
        .clock(clock), .resetn(resetn),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .io_addr(io_addr), .io_wdata(io_wdata), .io_we(io_we),
        .io_rdata(io_rdata), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Port model: registered read, write on io_we; contents preloaded in reset.
    logic [31:0] mem [16];
    always @(posedge clock) begin
        if (!resetn) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'hC0DE_0000 | 32'(i);
            mem[3]   <= 32'h0000_0015;
            io_rdata <= 32'h0;
        end else begin
            if (io_we) mem[io_addr] <= io_wdata;
            io_rdata <= mem[io_addr];
        end
    end

    typedef struct {
        logic        mst;
        logic        we;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct { logic mst; logic we; logic [3:0] addr; logic [31:0] wdata; } gnt_t;
    typedef struct { logic mst; logic we; logic [31:0] rdata; } rsp_t;

    gnt_t gnt_q[$];
    rsp_t rsp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every grant and response must match the next
    // expectation pushed by the stimulus.
    logic prev_gnt;
    always @(negedge clock) begin
        gnt_t g;
        rsp_t r;
        if (!resetn) begin
            prev_gnt = 1'b0;
        end else begin
            if (m0_gnt || m1_gnt) begin
                chk("gnt_onehot", {31'b0, m0_gnt & m1_gnt}, 32'd0);
                if (gnt_q.size() == 0) begin
                    chk("gnt_unexpected", 32'd1, 32'd0);
                end else begin
                    g = gnt_q.pop_front();
                    chk("gnt_owner", {31'b0, m1_gnt}, {31'b0, g.mst});
                    chk("gnt_io_we", {31'b0, io_we}, {31'b0, g.we});
                    chk("gnt_io_addr", {28'b0, io_addr}, {28'b0, g.addr});
                    if (g.we) chk("gnt_io_wdata", io_wdata, g.wdata);
                end
            end else begin
                chk("io_we_outside_issue", {31'b0, io_we}, 32'd0);
            end
            if (m0_rvalid || m1_rvalid) begin
                chk("rvalid_after_gnt", {31'b0, prev_gnt}, 32'd1);
                if (rsp_q.size() == 0) begin
                    chk("rvalid_unexpected", 32'd1, 32'd0);
                end else begin
                    r = rsp_q.pop_front();
                    chk("rsp_owner", {31'b0, m1_rvalid}, {31'b0, r.mst});
                    if (!r.we) chk("rsp_rdata", r.mst ? m1_rdata : m0_rdata, r.rdata);
                end
            end
            prev_gnt = m0_gnt | m1_gnt;
        end
    end

    task automatic drive(input logic mst, input logic req, input logic we,
                         input logic [3:0] addr, input logic [31:0] wdata);
        if (mst == M1) begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
        end else begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge, idle again.
    task automatic do_txn(input vec_t v);
        gnt_t g;
        rsp_t r;
        g.mst = v.mst; g.we = v.we; g.addr = v.addr; g.wdata = v.wdata;
        r.mst = v.mst; r.we = v.we; r.rdata = v.exp_rdata;
        gnt_q.push_back(g);
        rsp_q.push_back(r);
        drive(v.mst, 1'b1, v.we, v.addr, v.wdata);
        @(negedge clock);
        chk("txn_gnt_n1", {31'b0, (v.mst ? m1_gnt : m0_gnt)}, 32'd1);
        chk("txn_busy_issue", {31'b0, busy}, 32'd1);
        drive(v.mst, 1'b0, 1'b0, 4'h0, 32'h0);
        @(negedge clock);
        chk("txn_rvalid_n2", {31'b0, (v.mst ? m1_rvalid : m0_rvalid)}, 32'd1);
        chk("txn_rdata", v.mst ? m1_rdata : m0_rdata, v.exp_rdata);
        @(negedge clock);
        chk("txn_busy_idle", {31'b0, busy}, 32'd0);
        chk("txn_addr_hold", {28'b0, io_addr}, {28'b0, v.addr});
        chk("txn_rdata_hold", v.mst ? m1_rdata : m0_rdata, v.exp_rdata);
    endtask

    vec_t vecs[6];
    logic [9:0] pat;

    initial begin
        gnt_t g;
        rsp_t r;
        vec_t v;

        resetn = 1'b0;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;

        vecs[0] = '{mst: M0, we: 1'b0, addr: SW_LO,    wdata: 32'h0,         exp_rdata: 32'h0000_0015};
        vecs[1] = '{mst: M1, we: 1'b1, addr: HEX23,    wdata: 32'h0000_00A5, exp_rdata: 32'h0};
        vecs[2] = '{mst: M1, we: 1'b0, addr: HEX23,    wdata: 32'h0,         exp_rdata: 32'h0000_00A5};
        vecs[3] = '{mst: M0, we: 1'b1, addr: OPERATOR, wdata: 32'hDEAD_BEEF, exp_rdata: 32'h0000_0015};
        vecs[4] = '{mst: M0, we: 1'b0, addr: OPERATOR, wdata: 32'h0,         exp_rdata: 32'hDEAD_BEEF};
        vecs[5] = '{mst: M1, we: 1'b0, addr: HEX01,    wdata: 32'h0,         exp_rdata: 32'hC0DE_0000};

        repeat (2) @(negedge clock);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_io_we", {31'b0, io_we}, 32'd0);
        chk("rst_io_addr", {28'b0, io_addr}, 32'd0);
        chk("rst_io_wdata", io_wdata, 32'd0);
        chk("rst_gnt", {30'b0, m1_gnt, m0_gnt}, 32'd0);
        chk("rst_rvalid", {30'b0, m1_rvalid, m0_rvalid}, 32'd0);
        chk("rst_m0_rdata", m0_rdata, 32'd0);
        chk("rst_m1_rdata", m1_rdata, 32'd0);
        resetn = 1'b1;
        @(negedge clock);
        chk("post_rst_busy", {31'b0, busy}, 32'd0);

        for (int i = 0; i < 6; i++) do_txn(vecs[i]);

        // Back-to-back reads by M0 with req held: one access every 2 cycles.
        for (int i = 0; i < 4; i++) begin
            g = '{mst: M0, we: 1'b0, addr: SW_LO, wdata: 32'h0};
            r = '{mst: M0, we: 1'b0, rdata: 32'h0000_0015};
            gnt_q.push_back(g);
            rsp_q.push_back(r);
        end
        drive(M0, 1'b1, 1'b0, SW_LO, 32'h0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            chk("b2b_gnt", {31'b0, m0_gnt}, {31'b0, k[0]});
            chk("b2b_rvalid", {31'b0, m0_rvalid}, {31'b0, ~k[0]});
            chk("b2b_busy", {31'b0, busy}, 32'd1);
            if (k == 7) drive(M0, 1'b0, 1'b0, 4'h0, 32'h0);
        end
        @(negedge clock);
        chk("b2b_idle", {31'b0, busy}, 32'd0);

        // Reset during RESP: no rvalid may appear, outputs return to reset values.
        g = '{mst: M0, we: 1'b0, addr: OPERATOR, wdata: 32'h0};
        gnt_q.push_back(g);
        drive(M0, 1'b1, 1'b0, OPERATOR, 32'h0);
        @(negedge clock);
        drive(M0, 1'b0, 1'b0, 4'h0, 32'h0);
        @(posedge clock);
        #2 resetn = 1'b0;
        #1;
        chk("midrst_rvalid", {31'b0, m0_rvalid}, 32'd0);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_io_addr", {28'b0, io_addr}, 32'd0);
        chk("midrst_m0_rdata", m0_rdata, 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        v = '{mst: M0, we: 1'b0, addr: SW_LO, wdata: 32'h0, exp_rdata: 32'h0000_0015};
        do_txn(v);

        // Contention: both masters request continuously from a fresh reset.
`ifdef IO_ARB_RR_EN
        pat = 10'b10_1010_1010;
`else
        pat = 10'b10_0001_0000;
`endif
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            g.mst = pat[i]; g.we = 1'b0; g.wdata = 32'h0;
            g.addr = pat[i] ? SW_HI : HEX45;
            r.mst = pat[i]; r.we = 1'b0;
            r.rdata = pat[i] ? 32'hC0DE_0004 : 32'hC0DE_0002;
            gnt_q.push_back(g);
            rsp_q.push_back(r);
        end
        drive(M0, 1'b1, 1'b0, HEX45, 32'h0);
        drive(M1, 1'b1, 1'b0, SW_HI, 32'h0);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            chk("cont_spacing", {31'b0, m0_gnt | m1_gnt}, {31'b0, k[0]});
            if (k == 19) begin
                drive(M0, 1'b0, 1'b0, 4'h0, 32'h0);
                drive(M1, 1'b0, 1'b0, 4'h0, 32'h0);
            end
        end
        @(negedge clock);
        chk("cont_idle", {31'b0, busy}, 32'd0);

        repeat (2) @(negedge clock);
        chk("gnt_q_drained", gnt_q.size(), 32'd0);
        chk("rsp_q_drained", rsp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
